// File: rtl/multicycle_sequencer_pkg.sv
// Shared opcode map and sequencer state encoding for the little-computer core.
package multicycle_sequencer_pkg;

  localparam int OP_WIDTH    = 4;
  localparam int SEQ_STATE_W = 3;

  // R-type opcodes occupy 4'b00xx; everything not listed here executes as a NOP.
  localparam logic [OP_WIDTH-1:0] OP_ADDI = 4'h4;
  localparam logic [OP_WIDTH-1:0] OP_LW   = 4'h5;
  localparam logic [OP_WIDTH-1:0] OP_SW   = 4'h6;
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = 4'h7;
  localparam logic [OP_WIDTH-1:0] OP_HALT = 4'hF;

  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_FETCH  = 3'd0,
    SEQ_DECODE = 3'd1,
    SEQ_EXEC   = 3'd2,
    SEQ_MEM    = 3'd3,
    SEQ_WB     = 3'd4,
    SEQ_HALT   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/multicycle_sequencer_perf_counter.sv
// Cycle and retirement counters for the multicycle sequencer (SEQ_PERF_CNT_EN builds only).
module seq_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  // Both counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (count_en) cycle_count   <= cycle_count + 1'b1;
      if (retire)   retired_count <= retired_count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with a req/ack memory port.
// Define SEQ_PERF_CNT_EN to add the cycle_count / retired_count performance counters.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int OP_W = OP_WIDTH
`ifdef SEQ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic             branch_taken,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             halted
`ifdef SEQ_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_count
  , output logic [CNT_W-1:0] retired_count
`endif
);

  seq_state_e state, next_state;

  logic is_lw, is_sw, is_beq, is_addi, is_rtype, is_halt;

  assign is_lw    = (op == OP_W'(OP_LW));
  assign is_sw    = (op == OP_W'(OP_SW));
  assign is_beq   = (op == OP_W'(OP_BEQ));
  assign is_addi  = (op == OP_W'(OP_ADDI));
  assign is_halt  = (op == OP_W'(OP_HALT));
  assign is_rtype = (op[OP_W-1 -: 2] == 2'b00);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= SEQ_FETCH;
    else     state <= next_state;
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    next_state   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_branch    = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    halted       = 1'b0;
    // Reset forces all strobes low immediately, abandoning any open request.
    if (!rst) begin
      case (state)
        SEQ_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_load    = 1'b1;
            next_state = SEQ_DECODE;
          end
        end
        SEQ_DECODE: next_state = is_halt ? SEQ_HALT : SEQ_EXEC;
        SEQ_EXEC: begin
          if (is_beq) begin
            pc_branch  = branch_taken;
            pc_inc     = !branch_taken;
            next_state = SEQ_FETCH;
          end else if (is_lw || is_sw) begin
            next_state = SEQ_MEM;
          end else if (is_rtype || is_addi) begin
            next_state = SEQ_WB;
          end else begin
            pc_inc     = 1'b1;
            next_state = SEQ_FETCH;
          end
        end
        SEQ_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_sw;
          if (mem_ack) begin
            pc_inc     = is_sw;
            next_state = is_sw ? SEQ_FETCH : SEQ_WB;
          end
        end
        SEQ_WB: begin
          rf_we      = 1'b1;
          wb_sel     = is_lw;
          pc_inc     = 1'b1;
          next_state = SEQ_FETCH;
        end
        SEQ_HALT: halted = 1'b1;
        default:  next_state = SEQ_FETCH;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // A HALT retires on its DECODE->HALT edge even though it never touches the PC.
  logic retire, count_en;
  assign retire   = pc_inc || pc_branch || (!rst && state == SEQ_DECODE && is_halt);
  assign count_en = !rst && state != SEQ_HALT;

  seq_perf_counter #(.CNT_W(CNT_W)) u_perf (
    .clk           (clk),
    .rst           (rst),
    .count_en      (count_en),
    .retire        (retire),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-instruction cycle scripts built from the latency/strobe rules, random programs and memory waits.
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] op;
  logic       branch_taken, mem_ack;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_branch, rf_we, wb_sel, halted;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_count, retired_count;
`endif

  multicycle_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .branch_taken (branch_taken),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .pc_branch    (pc_branch),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .halted       (halted)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_count   (cycle_count)
    , .retired_count (retired_count)
`endif
  );

  always #5 clk = ~clk;

  // Output vector order: req we sel irl inc br rfw wbs hlt
  logic [8:0] outs;
  assign outs = {mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_branch, rf_we, wb_sel, halted};

  int checks   = 0;
  int failures = 0;
  int m_cyc    = 0;
  int m_ret    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ov(input bit req, we, sel, irl, inc, br, rfw, wbs, hlt);
    return {req, we, sel, irl, inc, br, rfw, wbs, hlt};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drives one cycle's inputs at the negedge, checks outputs, and advances to the next negedge.
  task automatic step(input string tag, input logic ack, input logic br, input logic [8:0] exp);
    mem_ack      = ack;
    branch_taken = br;
    #2;
    check(tag, outs, exp);
    if (!exp[0]) m_cyc++;
    if (exp[4] || exp[3]) m_ret++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
`ifdef SEQ_PERF_CNT_EN
    check({tag, "_cycles"}, cycle_count, m_cyc);
    check({tag, "_retired"}, retired_count, m_ret);
`endif
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ack      = rb();
      branch_taken = rb();
      op           = 4'($urandom);
      #2;
      check("rst_outs", outs, 9'h0);
      @(posedge clk);
      @(negedge clk);
    end
    rst   = 1'b0;
    m_cyc = 0;
    m_ret = 0;
  endtask

  task automatic run_instr(input logic [3:0] opc, input logic br, input int fwait, input int mwait);
    logic is_lw, is_sw, mem_op, alu_op;
    is_lw  = (opc == OP_LW);
    is_sw  = (opc == OP_SW);
    mem_op = is_lw || is_sw;
    alu_op = (opc[3:2] == 2'b00) || (opc == OP_ADDI);
    check_counts("instr_start");
    for (int i = 0; i < fwait; i++) begin
      op = 4'($urandom);
      step("fetch_wait", 1'b0, rb(), ov(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    op = 4'($urandom);
    step("fetch_ack", 1'b1, rb(), ov(1, 0, 0, 1, 0, 0, 0, 0, 0));
    op = opc;
    step("decode", rb(), rb(), 9'h0);
    if (opc == OP_HALT) begin
      m_ret++;
      for (int i = 0; i < 20; i++) step("halt", rb(), rb(), ov(0, 0, 0, 0, 0, 0, 0, 0, 1));
      return;
    end
    if (opc == OP_BEQ) begin
      step("exec_beq", rb(), br, ov(0, 0, 0, 0, !br, br, 0, 0, 0));
      return;
    end
    if (!mem_op && !alu_op) begin
      step("exec_nop", rb(), rb(), ov(0, 0, 0, 0, 1, 0, 0, 0, 0));
      return;
    end
    step("exec", rb(), rb(), 9'h0);
    if (mem_op) begin
      for (int i = 0; i < mwait; i++)
        step("mem_wait", 1'b0, rb(), ov(1, is_sw, 1, 0, 0, 0, 0, 0, 0));
      step("mem_ack", 1'b1, rb(), ov(1, is_sw, 1, 0, is_sw, 0, 0, 0, 0));
      if (is_sw) return;
    end
    step("wb", rb(), rb(), ov(0, 0, 0, 0, 1, 0, 1, is_lw, 0));
  endtask

  function automatic logic [3:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return {2'b00, 2'($urandom)};
      1:       return OP_ADDI;
      2:       return OP_LW;
      3:       return OP_SW;
      4:       return OP_BEQ;
      default: return 4'($urandom_range(8, 14));
    endcase
  endfunction

  initial begin
    rst = 1'b1; op = '0; mem_ack = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    do_reset(2);

    // ADDI, taken BEQ, HALT on zero-wait memory: 9 counted cycles, 3 retirements.
    run_instr(OP_ADDI, 1'b0, 0, 0);
    run_instr(OP_BEQ,  1'b1, 0, 0);
    run_instr(OP_HALT, 1'b0, 0, 0);
`ifdef SEQ_PERF_CNT_EN
    check("perf_cycles_9", cycle_count, 32'd9);
    check("perf_retired_3", retired_count, 32'd3);
`endif
    check_counts("after_halt");
    do_reset(2);

    run_instr(OP_LW,   1'b0, 0, 2);
    run_instr(OP_BEQ,  1'b1, 0, 0);
    run_instr(OP_BEQ,  1'b0, 0, 0);
    run_instr(OP_SW,   1'b0, 1, 1);
    run_instr(OP_HALT, 1'b0, 0, 0);
    do_reset(2);

    // Reset abandons a pending fetch; the next fetch starts cleanly.
    op = 4'($urandom);
    step("fetch_wait_pre_rst", 1'b0, 1'b0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step("fetch_wait_pre_rst", 1'b0, 1'b0, ov(1, 0, 0, 0, 0, 0, 0, 0, 0));
    do_reset(3);
    run_instr(OP_ADDI, 1'b0, 0, 0);
    run_instr(OP_HALT, 1'b0, 0, 0);
    do_reset(1);

    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < 10; k++)
        run_instr(rand_op(), rb(), $urandom_range(0, 3), $urandom_range(0, 3));
      run_instr(OP_HALT, 1'b0, $urandom_range(0, 2), 0);
      check_counts("prog_end");
      do_reset($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multicycle control FSM for the little-computer core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives PC update, IR load, register-file write strobe and a req/ack handshake to the unified instruction/data memory.
- Sits beside the combinational opcode decoder. Takes the IR opcode field plus the ALU branch result, and gates the decoder's static signals into per-cycle strobes.

Parameters:
- OP_W, 4, opcode width; equals `OpWidth.
- CNT_W, 32, width of performance counters; used only with SEQ_PERF_CNT_EN.

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  OP_W  opcode field of IR; valid from DECODE onward
- branch_taken  in  1  ALU compare result for BEQ; valid in EXEC
- mem_ack  in  1  memory completes current request this cycle
- mem_req  out  1  memory request; held until ack
- mem_we  out  1  write request (SW); valid while mem_req
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_load  out  1  load IR from memory read data
- pc_inc  out  1  PC <= PC + 1 this edge
- pc_branch  out  1  PC <= PC + 1 + imm this edge
- rf_we  out  1  register-file write strobe
- wb_sel  out  1  0 = ALU result, 1 = memory read data
- halted  out  1  core stopped; sticky until rst
- cycle_count  out  CNT_W  present only with SEQ_PERF_CNT_EN
- retired_count  out  CNT_W  present only with SEQ_PERF_CNT_EN

Behaviour:
- State register encodes FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are a Moore/Mealy decode of state, op, mem_ack and branch_taken. No output registers.
- rst, including mid-transaction: state <= FETCH next edge. While rst is high, all outputs are 0. mem_req drops immediately; memory must tolerate an abandoned request.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - mem_ack=1: ir_load=1 same cycle, then -> DECODE.
  - Otherwise stay in FETCH with mem_req held.
- DECODE: one cycle, no strobes. op==`OP_HALT -> HALT; else -> EXEC.
- EXEC: one cycle.
  - BEQ: pc_branch=branch_taken, pc_inc=!branch_taken, -> FETCH.
  - LW/SW -> MEM.
  - R-type (op[OP_W-1:OP_W-2]==00) or ADDI -> WB.
  - Any other op: treated as NOP, pc_inc=1, -> FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(op==`OP_SW); wait for mem_ack.
  - Ack with LW -> WB.
  - Ack with SW: pc_inc=1, -> FETCH.
- WB: rf_we=1, wb_sel=(op==`OP_LW), pc_inc=1, -> FETCH.
- HALT: halted=1. All other outputs 0. Stays in HALT until rst.
- Handshake rules:
  - Zero-wait ack (ack in the first req cycle) is legal.
  - mem_ack while mem_req=0 is ignored.
  - mem_addr_sel and mem_we are stable for the whole request.
- Exclusivity: pc_inc and pc_branch are never both 1. rf_we only in WB. ir_load only in FETCH on ack.
- Latency with zero-wait memory: R-type/ADDI 4 cycles, LW 5, SW 4, BEQ 3, NOP 3. Each memory wait cycle adds 1.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - cycle_count increments every non-reset cycle while not halted.
  - retired_count increments on every edge where pc_inc or pc_branch is 1; HALT counts as one retirement on the DECODE->HALT edge.
  - Both reset to 0 and wrap at 2^CNT_W.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- defs.vh gains `OP_SW (if not present) and the state encodings `SEQ_FETCH.. `SEQ_HALT, with `SeqStateWidth=3.
- Opcode macros are reused; no local opcode literals.
- Sub-module seq_perf_counter: the two counters, instantiated only under SEQ_PERF_CNT_EN. The FSM stays in this module.

Test Plan:
- Reset then ADDI, mem_ack tied 1:
  - ir_load in cycle 0.
  - rf_we=1, wb_sel=0 and pc_inc=1 in cycle 3.
  - mem_req=1 again in cycle 4.
- LW with 2 wait cycles in MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=0 held for 3 cycles.
  - Then WB with wb_sel=1; 7 cycles total.
- BEQ with branch_taken=1, then 0: pc_branch=1 and pc_inc=0 in EXEC, then the reverse. Each instruction takes 3 cycles.
- SW then HALT:
  - SW: mem_we=1 in MEM, pc_inc on ack.
  - HALT: halted=1 from cycle 2 of its fetch and stays 1 for 20 cycles with all strobes 0.
- rst asserted during FETCH wait with mem_req=1: mem_req=0 while rst is high. After release, FETCH restarts with mem_req=1. A stray mem_ack during rst causes no ir_load.
- SEQ_PERF_CNT_EN: run ADDI, BEQ (taken), HALT with zero-wait memory, then hold: retired_count=3 and cycle_count=9 (4+3+2 cycles to reach HALT).
